rdma_frame_fifo: RTL and testbench

Buffers the 64-bit complex-sample stream that the RDMA engine emits on its FIFO-style write port (`out_r_din` / `out_r_write` / `out_r_full_n`) and presents it to the FFT core as an AXI4-Stream. It inserts `tlast` on every 2^FRAME_LOG2-th sample so the core sees framed transforms. It sits directly downstream of the DMA wrapper's read path and upstream of the FFT core input, and also flags writes attempted while full.

---
 rtl/rdma_frame_fifo_if.sv | 41 ++++
 rtl/rdma_frame_fifo.sv | 118 +++++++++++
 tb/tb_rdma_frame_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdma_frame_fifo_if.sv
// rdma_frame_fifo_if
//   Groups the two handshakes of rdma_frame_fifo on one bundle:
//   - FIFO-style write port from the RDMA engine: in_din, in_write, in_full_n
//   - AXI4-Stream master toward the FFT core: m_axis_tdata, m_axis_tvalid,
//     m_axis_tready, m_axis_tlast
//   Modports:
//   - slave  : view of the FIFO itself (accepts writes, drives the stream)
//   - master : view of the surrounding logic (RDMA engine + FFT core side)
// Parameters:
//   DATA_W : sample width ([63:32] imag, [31:0] real for the default 64)
interface rdma_frame_fifo_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] in_din;
    logic              in_write;
    logic              in_full_n;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport slave (
        input  in_din,
        input  in_write,
        output in_full_n,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport master (
        output in_din,
        output in_write,
        input  in_full_n,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/rdma_frame_fifo.sv
// rdma_frame_fifo
//   Buffers the RDMA engine's sample stream in a small circular FIFO and
//   presents it to the FFT core as AXI4-Stream, asserting tlast on every
//   2^FRAME_LOG2-th output sample. Writes attempted while full are dropped
//   and flagged on a sticky overflow_err.
// Ports:
//   ap_clk       : clock, rising edge
//   ap_rst_n     : asynchronous active-low reset
//   clear        : synchronous flush pulse, overrides all other activity
//   bus          : rdma_frame_fifo_if.slave (write port + AXI4-Stream out)
//   overflow_err : sticky, set by in_write while in_full_n = 0
//   frame_cnt    : completed-frame counter (only with RDMA_FRAME_CNT_EN)
// Parameters:
//   DATA_W     : sample width
//   DEPTH_LOG2 : FIFO depth = 2^DEPTH_LOG2 (1..8)
//   FRAME_LOG2 : samples per frame = 2^FRAME_LOG2 (1..16)
// Configuration macro:
//   RDMA_FRAME_CNT_EN : adds the frame_cnt port and its 32-bit counter
module rdma_frame_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned FRAME_LOG2 = 10
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                clear,
    rdma_frame_fifo_if.slave    bus,
`ifdef RDMA_FRAME_CNT_EN
    output logic                overflow_err,
    output logic [31:0]         frame_cnt
`else
    output logic                overflow_err
`endif
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // count value meaning "every entry occupied"
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [FRAME_LOG2-1:0] sample_idx;

    logic push;
    logic pop;
    logic full_n;
    logic valid;
    logic last;

    // Flags come from registered count only, so there is no path from
    // tready to in_full_n nor from in_write to tvalid.
    always_comb begin
        full_n = (count != COUNT_FULL);
        valid  = (count != '0);
        last   = (sample_idx == '1);
        push   = bus.in_write & full_n;
        pop    = valid & bus.m_axis_tready;
    end

    assign bus.in_full_n     = full_n;
    assign bus.m_axis_tvalid = valid;
    assign bus.m_axis_tlast  = last;
    assign bus.m_axis_tdata  = mem[rd_ptr];

    // Storage is intentionally not reset; its content is don't-care until
    // count says an entry is valid.
    always_ff @(posedge ap_clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= bus.in_din;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_idx   <= '0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_idx   <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                sample_idx <= sample_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.in_write && !full_n) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef RDMA_FRAME_CNT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frame_cnt <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
        end else if (pop && last) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rdma_frame_fifo.sv
// tb_rdma_frame_fifo
//   Directed bench for rdma_frame_fifo (DEPTH_LOG2=4, FRAME_LOG2=2) with a
//   per-cycle queue model plus hand-computed checks for each scenario.
module tb_rdma_frame_fifo;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned FRAME_LOG2 = 2;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned FRAME      = 4;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    logic clear    = 1'b0;
    logic overflow_err;
`ifdef RDMA_FRAME_CNT_EN
    logic [31:0] frame_cnt;
`endif

    rdma_frame_fifo_if #(.DATA_W(DATA_W)) bus ();

    rdma_frame_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .FRAME_LOG2(FRAME_LOG2)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .clear       (clear),
        .bus         (bus.slave),
`ifdef RDMA_FRAME_CNT_EN
        .overflow_err(overflow_err),
        .frame_cnt   (frame_cnt)
`else
        .overflow_err(overflow_err)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];
    logic [63:0] out_log[$];
    bit          last_log[$];
    int unsigned pop_idx;
    int unsigned pushes;
    logic        ovf_m;
    logic [31:0] fc_m;
    logic        stall_prev;
    logic [63:0] stall_data;
    logic        stall_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pop_idx    = 0;
        ovf_m      = 1'b0;
        fc_m       = '0;
        stall_prev = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [63:0] d, input logic rdy, input logic clr);
        bus.in_write      = wr;
        bus.in_din        = d;
        bus.m_axis_tready = rdy;
        clear             = clr;
    endtask

    // Check current outputs against the model, update the model with this
    // cycle's handshakes, then advance to 1 time unit after the next edge.
    task automatic step();
        logic exp_last;
        logic full_m;
        full_m   = (q.size() == DEPTH);
        exp_last = ((pop_idx % FRAME) == FRAME - 1);
        check("tvalid", bus.m_axis_tvalid, q.size() != 0);
        check("in_full_n", bus.in_full_n, !full_m);
        check("overflow_err", overflow_err, ovf_m);
        check("tlast", bus.m_axis_tlast, exp_last);
`ifdef RDMA_FRAME_CNT_EN
        check("frame_cnt", frame_cnt, fc_m);
`endif
        if (stall_prev) begin
            check("stall_tdata", bus.m_axis_tdata, stall_data);
            check("stall_tlast", bus.m_axis_tlast, stall_last);
        end
        stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready && !clear;
        stall_data = bus.m_axis_tdata;
        stall_last = bus.m_axis_tlast;
        if (clear) begin
            q.delete();
            pop_idx = 0;
            ovf_m   = 1'b0;
            fc_m    = '0;
        end else begin
            if (q.size() != 0 && bus.m_axis_tready) begin
                check("tdata", bus.m_axis_tdata, q[0]);
                out_log.push_back(bus.m_axis_tdata);
                last_log.push_back(bus.m_axis_tlast);
                void'(q.pop_front());
                if (exp_last) fc_m++;
                pop_idx++;
            end
            if (bus.in_write) begin
                if (!full_m) begin
                    q.push_back(bus.in_din);
                    pushes++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        drive(0, '0, 0, 0);
        model_reset();
        pushes = 0;

        // Reset state, sampled between edges
        #12;
        check("rst_full_n", bus.in_full_n, 1);
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_tlast", bus.m_axis_tlast, 0);
        check("rst_ovf", overflow_err, 0);
`ifdef RDMA_FRAME_CNT_EN
        check("rst_frame_cnt", frame_cnt, 0);
`endif
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Fill 16 with tready=0; in_full_n drops only after the 16th
        for (int i = 0; i < 16; i++) begin
            drive(1, 64'h100 + 64'(i), 0, 0);
            step();
            check("fill_full_n", bus.in_full_n, (i != 15));
        end
        drive(1, 64'hDEAD, 0, 0);
        step();
        check("ovf_set", overflow_err, 1);
        check("full_head", bus.m_axis_tdata, 64'h100);

        // Full: simultaneous read + write, write refused, count -> 15
        drive(1, 64'hBEEF, 1, 0);
        out_log.delete();
        step();
        check("rw_full_n", bus.in_full_n, 1);
        drive(0, '0, 1, 0);
        repeat (15) step();
        check("drain_tvalid", bus.m_axis_tvalid, 0);
        check("drain_count", out_log.size(), 16);
        check("drain_last_word", out_log[15], 64'h10F);
        check("drain_first_word", out_log[0], 64'h100);

        // clear resets overflow_err
        drive(0, '0, 0, 1);
        step();
        drive(0, '0, 0, 0);
        check("clear_ovf", overflow_err, 0);
        step();

        // Framed stream 1..8 with tready=1
        out_log.delete();
        last_log.delete();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 64'(i), 1, 0);
            step();
        end
        drive(0, '0, 1, 0);
        repeat (2) step();
        check("frame_count_out", out_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("frame_data", out_log[i], 64'(i + 1));
            check("frame_tlast", last_log[i], (i == 3 || i == 7));
        end
`ifdef RDMA_FRAME_CNT_EN
        check("frame_cnt_2", frame_cnt, 2);
`endif

        // Random traffic over 4096 accepted samples
        begin
            int unsigned cyc;
            int unsigned start;
            cyc   = 0;
            start = pushes;
            while ((pushes - start) < 4096 && cyc < 30000) begin
                drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);
                step();
                cyc++;
            end
            check("rand_done", (pushes - start) >= 4096, 1);
        end
        drive(0, '0, 1, 0);
        repeat (20) step();
        check("rand_drained", bus.m_axis_tvalid, 0);

        // clear mid-frame with 5 words queued and overflow set
        drive(0, '0, 0, 1);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(1, 64'h200 + 64'(i), 0, 0);
            step();
        end
        drive(0, '0, 1, 0);
        repeat (11) step();
        check("pre_clear_ovf", overflow_err, 1);
        drive(1, 64'h777, 1, 1);
        step();
        drive(0, '0, 0, 0);
        check("clr_tvalid", bus.m_axis_tvalid, 0);
        check("clr_ovf", overflow_err, 0);
        check("clr_full_n", bus.in_full_n, 1);
`ifdef RDMA_FRAME_CNT_EN
        check("clr_frame_cnt", frame_cnt, 0);
`endif
        step();
        out_log.delete();
        last_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h300 + 64'(i), 1, 0);
            step();
        end
        drive(0, '0, 1, 0);
        repeat (2) step();
        check("post_clr_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("post_clr_data", out_log[i], 64'h300 + 64'(i));
            check("post_clr_tlast", last_log[i], (i == 3));
        end

        // Asynchronous reset mid-stream with tlast high and overflow set
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h400 + 64'(i), 0, 0);
            step();
        end
        drive(0, '0, 1, 0);
        repeat (3) step();
        for (int i = 0; i < 12; i++) begin
            drive(1, 64'h500 + 64'(i), 0, 0);
            step();
        end
        drive(0, '0, 0, 0);
        check("pre_rst_tlast", bus.m_axis_tlast, 1);
        check("pre_rst_ovf", overflow_err, 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("arst_tvalid", bus.m_axis_tvalid, 0);
        check("arst_full_n", bus.in_full_n, 1);
        check("arst_tlast", bus.m_axis_tlast, 0);
        check("arst_ovf", overflow_err, 0);
`ifdef RDMA_FRAME_CNT_EN
        check("arst_frame_cnt", frame_cnt, 0);
`endif
        model_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        drive(1, 64'h600, 1, 0);
        step();
        drive(0, '0, 1, 0);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
